grid_tile_renderer: RTL and testbench

Parametrised raster tile renderer between the VGA timing generator and the tile/grid memories. For each visible pixel it tracks which grid cell and which pixel within that cell is being drawn, fetches the cell type from grid memory, then fetches the pixel colour from tile ROM. It emits one RGB byte per pixel through a fixed-latency pipeline and replaces the fixed-size, unpipelined grid-to-video path.

---
 rtl/grid_tile_renderer.sv | 183 ++++++++++++++++++
 tb/tb_grid_tile_renderer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_tile_renderer.sv
// Raster tile renderer: maps each visible pixel to a grid cell, fetches the cell type, then the tile pixel colour.
// Optional cell blinking is built only when GRID_RENDER_BLINK_EN is defined.
module grid_tile_renderer #(
    parameter int          TILE_W       = 24,
    parameter int          TILE_H       = 24,
    parameter int          GRID_COLS    = 12,
    parameter int          GRID_ROWS    = 22,
    parameter int          ORIGIN_X     = 176,
    parameter int          ORIGIN_Y     = 0,
    parameter int          NUM_TYPES    = 9,
    parameter int          X_W          = 10,
    parameter int          GRID_AW      = 9,
    parameter int          TILE_AW      = 13,
    parameter logic [7:0]  BG_COLOR     = 8'h00,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               px_valid,
    input  logic [X_W-1:0]     px_x,
    input  logic [X_W-1:0]     px_y,
    output logic [GRID_AW-1:0] grid_addr,
    input  logic [7:0]         grid_data,
    output logic [TILE_AW-1:0] tile_addr,
    input  logic [7:0]         tile_data,
    output logic [7:0]         rgb_out,
    output logic               rgb_valid
);

    localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [X_W-1:0]     X_LO     = X_W'(ORIGIN_X);
    localparam logic [X_W-1:0]     Y_LO     = X_W'(ORIGIN_Y);
    localparam logic [X_W-1:0]     X_SPAN   = X_W'(GRID_COLS * TILE_W);
    localparam logic [X_W-1:0]     Y_SPAN   = X_W'(GRID_ROWS * TILE_H);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(TILE_W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(TILE_H - 1);
    localparam logic [GRID_AW-1:0] COLS_A   = GRID_AW'(GRID_COLS);
    localparam logic [TILE_AW-1:0] TILE_PIX = TILE_AW'(TILE_W * TILE_H);
    localparam logic [TILE_AW-1:0] TILE_WA  = TILE_AW'(TILE_W);

    logic [X_W-1:0]     w_dx, w_dy;
    logic               w_inArea, w_issue, w_lastPx;
    logic [COL_W-1:0]   w_colOff;
    logic [GRID_AW-1:0] w_cellCol, w_gridAddr;
    logic [3:0]         w_type;
    logic               w_typeOk, w_hide, w_unused;
    logic [TILE_AW-1:0] w_tileCalc;

    logic [COL_W-1:0]   r_colOff;
    logic [GRID_AW-1:0] r_cellCol, r_rowBase, r_gridHold;
    logic [ROW_W-1:0]   r_rowOff;
    logic [TILE_AW-1:0] r_tileHold;

    logic               r_p1Valid, r_p1InArea, r_p2Valid, r_p2Show;
    logic [COL_W-1:0]   r_p1ColOff;
    logic [ROW_W-1:0]   r_p1RowOff;

    // Offset subtraction wraps below the origin, so one unsigned compare covers both edges.
    always_comb begin
        w_dx       = px_x - X_LO;
        w_dy       = px_y - Y_LO;
        w_inArea   = (w_dx < X_SPAN) && (w_dy < Y_SPAN);
        w_issue    = px_valid && w_inArea;
        w_lastPx   = (w_dx == X_SPAN - 1'b1);
        w_colOff   = r_colOff;
        w_cellCol  = r_cellCol;
        if (px_x == X_LO) begin
            w_colOff  = '0;
            w_cellCol = '0;
        end
        w_gridAddr = r_rowBase + w_cellCol;
        grid_addr  = w_issue ? w_gridAddr : r_gridHold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_colOff   <= '0;
            r_cellCol  <= '0;
            r_rowOff   <= '0;
            r_rowBase  <= '0;
            r_gridHold <= '0;
        end else begin
            if (w_issue) begin
                r_gridHold <= w_gridAddr;
            end
            if (frame_start) begin
                r_colOff  <= '0;
                r_cellCol <= '0;
                r_rowOff  <= '0;
                r_rowBase <= '0;
            end else if (w_issue) begin
                if (w_colOff == COL_LAST) begin
                    r_colOff  <= '0;
                    r_cellCol <= w_cellCol + 1'b1;
                end else begin
                    r_colOff  <= w_colOff + 1'b1;
                    r_cellCol <= w_cellCol;
                end
                if (w_lastPx) begin
                    if (r_rowOff == ROW_LAST) begin
                        r_rowOff  <= '0;
                        r_rowBase <= r_rowBase + COLS_A;
                    end else begin
                        r_rowOff  <= r_rowOff + 1'b1;
                    end
                end
            end
        end
    end

`ifdef GRID_RENDER_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] r_frameCnt;
    logic            r_blinkPhase, r_p1Phase;

    // Phase is captured with the pixel so a frame_start behind it cannot change its colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frameCnt   <= '0;
            r_blinkPhase <= 1'b0;
            r_p1Phase    <= 1'b0;
        end else begin
            r_p1Phase <= r_blinkPhase;
            if (frame_start) begin
                if (r_frameCnt == FC_LAST) begin
                    r_frameCnt   <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_frameCnt <= r_frameCnt + 1'b1;
                end
            end
        end
    end

    assign w_hide   = grid_data[4] & r_p1Phase;
    assign w_unused = &{1'b0, grid_data[7:5]};
`else
    assign w_hide   = 1'b0;
    assign w_unused = &{1'b0, grid_data[7:4], (BLINK_FRAMES > 0)};
`endif

    assign w_type     = grid_data[3:0];
    assign w_typeOk   = (32'(w_type) < NUM_TYPES);
    assign w_tileCalc = TILE_AW'(w_type) * TILE_PIX
                      + TILE_AW'(r_p1RowOff) * TILE_WA
                      + TILE_AW'(r_p1ColOff);
    assign tile_addr  = (r_p1Valid && r_p1InArea) ? w_tileCalc : r_tileHold;

    // Three-stage pipeline: address issue, grid data returned, tile data returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1Valid  <= 1'b0;
            r_p1InArea <= 1'b0;
            r_p1ColOff <= '0;
            r_p1RowOff <= '0;
            r_p2Valid  <= 1'b0;
            r_p2Show   <= 1'b0;
            r_tileHold <= '0;
            rgb_valid  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            r_p1Valid  <= px_valid;
            r_p1InArea <= w_issue;
            r_p1ColOff <= w_colOff;
            r_p1RowOff <= r_rowOff;
            r_p2Valid  <= r_p1Valid;
            r_p2Show   <= r_p1InArea && w_typeOk && !w_hide;
            if (r_p1Valid && r_p1InArea) begin
                r_tileHold <= w_tileCalc;
            end
            rgb_valid <= r_p2Valid;
            if (r_p2Valid) begin
                rgb_out <= r_p2Show ? tile_data : BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_grid_tile_renderer.sv
// Scoreboard bench for grid_tile_renderer: stimulus pushes expected addresses/colours, a monitor pops and compares.
// Blink expectations follow GRID_RENDER_BLINK_EN.
module tb_grid_tile_renderer;

    localparam logic [7:0] BG = 8'h00;

    logic        clk = 1'b0;
    logic        reset, frame_start, px_valid;
    logic [9:0]  px_x, px_y;
    logic [8:0]  grid_addr;
    logic [7:0]  grid_data, tile_data, rgb_out;
    logic [12:0] tile_addr;
    logic        rgb_valid;

    logic [7:0] gridMem [0:511];
    logic [7:0] rom     [0:8191];

    int gQ[$];
    int tQ[$];
    int rQ[$];
    int checks = 0;
    int errors = 0;
    bit quiet  = 1'b0;
    bit prevPx = 1'b0;

    always #5 clk = ~clk;

    grid_tile_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .px_valid   (px_valid),
        .px_x       (px_x),
        .px_y       (px_y),
        .grid_addr  (grid_addr),
        .grid_data  (grid_data),
        .tile_addr  (tile_addr),
        .tile_data  (tile_data),
        .rgb_out    (rgb_out),
        .rgb_valid  (rgb_valid)
    );

    // Synchronous memories: data one cycle after the address.
    always @(posedge clk) begin
        grid_data <= gridMem[grid_addr];
        tile_data <= rom[tile_addr];
    end

    function automatic logic [7:0] romVal(input int a);
        return 8'(a * 13 + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Hand-computed expectations for selected pixels; -1 means not checked.
    task automatic lookup(input int x, input int y, output int eg, output int et, output int er);
        eg = -1; et = -1; er = -1;
        if      (x == 176 && y == 0)   begin eg = 0;   et = 1152; er = romVal(1152); end
        else if (x == 177 && y == 1)   begin eg = 0;   et = 1177; er = romVal(1177); end
        else if (x == 200 && y == 0)   begin eg = 1;   et = 1728; er = romVal(1728); end
        else if (x == 247 && y == 23)  begin eg = 2;   et = 5183; er = romVal(5183); end
        else if (x == 250 && y == 5)   begin eg = 3;   et = 6458; er = BG;           end
        else if (x == 175 && y == 0)   begin                      er = BG;           end
        else if (x == 464 && y == 0)   begin           et = 599;  er = BG;           end
        else if (x == 176 && y == 24)  begin eg = 12;  et = 576;  er = romVal(576);  end
        else if (x == 463 && y == 527) begin eg = 263; et = 1151; er = romVal(1151); end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit v, input bit fs, input bit rst,
                                 input int eg, input int et, input int er);
        @(posedge clk);
        #1;
        reset       = rst;
        frame_start = fs;
        px_valid    = v;
        px_x        = 10'(x);
        px_y        = 10'(y);
        if (v && !quiet) begin
            gQ.push_back(eg);
            tQ.push_back(et);
            rQ.push_back(er);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    endtask

    task automatic pixel(input int x, input int y);
        int eg, et, er;
        lookup(x, y, eg, et, er);
        applyStimulus(x, y, 1'b1, 1'b0, 1'b0, eg, et, er);
    endtask

    // Monitor: grid_addr in the issue cycle, tile_addr one cycle later, colour when rgb_valid.
    always @(negedge clk) begin
        int e;
        if (!quiet) begin
            if (px_valid) begin
                if (gQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL grid queue underflow");
                end else begin
                    e = gQ.pop_front();
                    if (e >= 0) checkOutput($sformatf("grid_addr@(%0d,%0d)", px_x, px_y), 32'(grid_addr), e);
                end
            end
            if (prevPx) begin
                if (tQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL tile queue underflow");
                end else begin
                    e = tQ.pop_front();
                    if (e >= 0) checkOutput("tile_addr", 32'(tile_addr), e);
                end
            end
            if (rgb_valid) begin
                if (rQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rgb queue underflow, got rgb_valid with nothing expected");
                end else begin
                    e = rQ.pop_front();
                    if (e >= 0) checkOutput("rgb_out", 32'(rgb_out), e);
                end
            end
        end
        prevPx = px_valid;
    end

    initial begin
        int expRgb;
        bit phase;
        reset = 1'b1; frame_start = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0;
        for (int i = 0; i < 512; i++) gridMem[i] = 8'h01;
        gridMem[0] = 8'h02;
        gridMem[1] = 8'h03;
        gridMem[2] = 8'h08;
        gridMem[3] = 8'h0B;
        for (int a = 0; a < 8192; a++) rom[a] = romVal(a);

        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        @(negedge clk);
        checkOutput("reset grid_addr", 32'(grid_addr), 0);
        checkOutput("reset tile_addr", 32'(tile_addr), 0);
        checkOutput("reset rgb_out", 32'(rgb_out), 0);
        checkOutput("reset rgb_valid", 32'(rgb_valid), 0);
        idle();

        // Frame: full lines near the top and at the last grid row, sparse lines between.
        $display("[TB] frame walk");
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        for (int y = 0; y < 528; y++) begin
            if (y <= 24 || y == 527) begin
                for (int x = 172; x < 468; x++) pixel(x, y);
            end else begin
                pixel(176, y);
                pixel(463, y);
            end
            idle();
        end
        repeat (4) idle();

        $display("[TB] frame_start clears counters");
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        pixel(176, 0);
        repeat (5) idle();

        $display("[TB] reset mid-line");
        quiet = 1'b1;
        for (int x = 296; x < 300; x++) applyStimulus(x, 50, 1'b1, 1'b0, 1'b0, -1, -1, -1);
        applyStimulus(300, 50, 1'b1, 1'b0, 1'b1, -1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            idle();
            @(negedge clk);
            checkOutput("rgb_valid after reset", 32'(rgb_valid), 0);
        end
        gQ.delete(); tQ.delete(); rQ.delete();
        quiet = 1'b0;
        idle();
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        pixel(176, 0);
        repeat (5) idle();

        $display("[TB] blink frames");
        gridMem[0] = 8'h13;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle();
        for (int f = 0; f <= 60; f++) begin
            if (f > 0) applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
`ifdef GRID_RENDER_BLINK_EN
            phase = (f >= 30 && f < 60);
`else
            phase = 1'b0;
`endif
            expRgb = phase ? int'(BG) : int'(romVal(1728));
            applyStimulus(176, 0, 1'b1, 1'b0, 1'b0, 0, 1728, expRgb);
        end

        for (int i = 0; i < 20 && rQ.size() != 0; i++) idle();
        repeat (2) idle();
        if (rQ.size() != 0 || tQ.size() != 0 || gQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain timeout: %0d colours still expected", rQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
